// File: rtl/scpu_ctrl_if.sv
// Instruction-fetch and ALU operand/result bundle between the sequencer and its memory/ALU.
// master = sequencer side, slave = memory/ALU side.
interface scpu_ctrl_if #(
    parameter int PC_W = 6
);
    logic [PC_W-1:0] imem_addr;
    logic            imem_rd;
    logic [7:0]      imem_rdata;
    logic [1:0]      ctrl_op;
    logic [8:0]      ctrl_rs;
    logic [8:0]      ctrl_rd;
    logic [8:0]      ex_dout;

    modport master (
        output imem_addr,
        output imem_rd,
        input  imem_rdata,
        output ctrl_op,
        output ctrl_rs,
        output ctrl_rd,
        input  ex_dout
    );

    modport slave (
        input  imem_addr,
        input  imem_rd,
        output imem_rdata,
        input  ctrl_op,
        input  ctrl_rs,
        input  ctrl_rd,
        output ex_dout
    );
endinterface

// File: rtl/scpu_ctrl.sv
// 8-bit CPU sequencer with 4x9 register file; LDI/JMP/HALT take 2 cycles from FETCH, ALU ops 3.
// No backpressure: imem answers one cycle after imem_rd and the ALU is combinational.
module scpu_ctrl #(
    parameter int PC_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    scpu_ctrl_if.master     bus,
    output logic            busy,
    output logic            halted,
    output logic [PC_W-1:0] pc,
    output logic            carry,
    input  logic [1:0]      dbg_sel,
    output logic [8:0]      dbg_data
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [1:0] CL_ALU = 2'b00;
    localparam logic [1:0] CL_LDI = 2'b01;
    localparam logic [1:0] CL_JMP = 2'b10;

    logic [2:0]      state;
    logic [3:0][8:0] regs;
    logic [1:0]      ex_dst;
    logic [1:0]      op_q;
    logic [8:0]      rs_q;
    logic [8:0]      rd_q;

    logic [7:0]      ins;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] jmp_tgt;

    assign ins     = bus.imem_rdata;
    assign pc_inc  = pc + PC_W'(1);
    assign jmp_tgt = PC_W'(ins[5:0]);

    assign bus.imem_addr = pc;
    assign bus.imem_rd   = (state == S_FETCH);
    assign bus.ctrl_op   = op_q;
    assign bus.ctrl_rs   = rs_q;
    assign bus.ctrl_rd   = rd_q;

    assign busy     = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
    assign dbg_data = regs[dbg_sel];

    // Operands are latched in DECODE so EXEC can overwrite a source when dd == ss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= '0;
            regs   <= '0;
            carry  <= 1'b0;
            halted <= 1'b0;
            ex_dst <= 2'd0;
            op_q   <= 2'd0;
            rs_q   <= 9'd0;
            rd_q   <= 9'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (ins[7:6])
                        CL_ALU: begin
                            op_q   <= ins[5:4];
                            rd_q   <= regs[ins[3:2]];
                            rs_q   <= regs[ins[1:0]];
                            ex_dst <= ins[3:2];
                            state  <= S_EXEC;
                        end
                        CL_LDI: begin
                            regs[ins[5:4]] <= {5'b0, ins[3:0]};
                            pc             <= pc_inc;
                            state          <= S_FETCH;
                        end
                        CL_JMP: begin
                            pc    <= jmp_tgt;
                            state <= S_FETCH;
                        end
                        default: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                    endcase
                end
                S_EXEC: begin
                    regs[ex_dst] <= bus.ex_dout;
                    carry        <= bus.ex_dout[8];
                    pc           <= pc_inc;
                    state        <= S_FETCH;
                end
                S_HALT: begin
                    if (start) begin
                        halted <= 1'b0;
                        pc     <= '0;
                        state  <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/scpu_ctrl.md
Name: scpu_ctrl

Overview:
Multi-cycle sequencer for the 8-bit processor. It fetches instructions from a synchronous instruction memory, decodes them, and holds a 4-entry x 9-bit register file. It drives the ALU operand and opcode inputs and writes the 9-bit ALU result back. Bit 8 of each result is kept as the carry/borrow flag.

Parameters:
PC_W, 6, instruction address width; the PC wraps modulo 2^PC_W.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; starts execution from IDLE or HALT
imem_addr  out  PC_W  instruction fetch address (current PC)
imem_rd  out  1  fetch strobe; imem_rdata is valid on the following cycle
imem_rdata  in  8  instruction word
ctrl_op  out  2  ALU opcode: 00 AND, 01 OR, 10 ADD, 11 SUB (rd - rs)
ctrl_rs  out  9  ALU source operand
ctrl_rd  out  9  ALU destination operand
ex_dout  in  9  ALU result (combinational from ctrl_*)
busy  out  1  high while executing
halted  out  1  high after a HALT instruction, until restart
pc  out  PC_W  current program counter
carry  out  1  bit 8 of the last ALU result written back
dbg_sel  in  2  register-file debug read index
dbg_data  out  9  combinational read of reg[dbg_sel]; pre-edge value on a same-cycle write

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n), named clk/rst_n as in the rest of the design.
- Reset values (immediate, any state, including mid-instruction):
  - state=IDLE; pc=0; all registers 0; carry=0; busy=0; halted=0.
  - imem_rd=0; ctrl_op=0; ctrl_rs=0; ctrl_rd=0.
  - An instruction in flight is discarded; nothing is written back.
- Instruction encoding (ir[7:0]):
  - 00 oo dd ss: ALU op oo; reg[dd] <= reg[dd] op reg[ss].
  - 01 dd iiii: LDI; reg[dd] <= {5'b0, iiii}; carry unchanged.
  - 10 tttttt: JMP; pc <= tttttt, zero-extended or truncated to PC_W.
  - 11 xxxxxx: HALT.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE:
  - start=1 -> FETCH, pc unchanged.
  - start=0 -> stay.
- FETCH:
  - imem_rd=1, imem_addr=pc (imem_addr is always pc).
  - -> DECODE unconditionally.
  - imem_rd=0 in every other state.
- DECODE (ir <= imem_rdata, then act on it):
  - ALU class: register ctrl_op<=oo, ctrl_rd<=reg[dd], ctrl_rs<=reg[ss]; -> EXEC.
  - LDI: write reg; pc<=pc+1; -> FETCH.
  - JMP: pc<=target; -> FETCH.
  - HALT: halted<=1; pc holds at the HALT address; -> HALT.
- EXEC:
  - reg[dd]<=ex_dout (all 9 bits); carry<=ex_dout[8]; pc<=pc+1; -> FETCH.
  - dd==ss is legal: operands were captured in DECODE.
- HALT:
  - start=1 -> halted<=0, pc<=0, FETCH; registers and carry retained.
  - start=0 -> stay.
- Latency from FETCH entry: LDI/JMP/HALT 2 cycles; ALU instructions 3 cycles.
- ctrl_* hold their last values outside EXEC.
- busy=1 in FETCH, DECODE and EXEC; busy=0 in IDLE and HALT.
- start while busy is ignored.
- pc+1 at 2^PC_W-1 wraps to 0.
- Arithmetic:
  - Operands are 9-bit register contents; results are 9-bit modulo 512.
  - SUB borrow appears as ex_dout[8]=1.
- Unconnected or X imem_rdata is not masked; the bench must drive a valid word.

Test Plan:
- Reset: hold rst_n=0 with start toggling -> every output reads 0 and state stays IDLE; release -> no fetch until start.
- Add program:
  - imem[0..3] = 0x45 (LDI r0,5), 0x53 (LDI r1,3), 0x21 (ADD r0,r1), 0xC0 (HALT); pulse start.
  - Required: reg0=9'h008, reg1=9'h003, carry=0, halted=1, pc=3, busy low.
  - halted rises 9 cycles after the FETCH of address 0.
- Subtract borrow:
  - 0x61 (LDI r2,1), 0x3E (SUB r3,r2), 0xC0.
  - Required: reg3=9'h1FF, carry=1.
  - A following 0x13 (OR r0,r3) leaves carry=1.
- Jump and wrap:
  - 0x8A at address 0 -> next imem_addr=10.
  - LDI at address 63 (PC_W=6) -> next imem_addr=0.
- Halt/restart:
  - After HALT, start pulses while busy are ignored.
  - start in HALT -> halted falls next cycle, fetch restarts at pc=0, registers preserved (observe via dbg_data).
- Async reset mid-EXEC:
  - Assert rst_n low during the EXEC of 0x21.
  - Required: outputs clear immediately (no clock edge needed), reg0 is not written, and the next start fetches address 0.
